// File: rtl/host_mem_bridge_pkg.sv
// ---------------------------------------------------------------------------
// host_mem_bridge_pkg
// Shared types for the host/CPU memory bridge: the host command opcodes,
// the bridge FSM states and the default byte address where the CPU
// instruction region begins.
// ---------------------------------------------------------------------------
package host_mem_bridge_pkg;

    typedef enum logic [1:0] {
        OP_STOP = 2'd0,
        OP_LOAD = 2'd1,
        OP_DUMP = 2'd2,
        OP_RUN  = 2'd3
    } cmdOp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_RUN  = 2'd3
    } bridgeState_t;

    localparam logic [31:0] I_START_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/bridge_skid_fifo.sv
// ---------------------------------------------------------------------------
// bridge_skid_fifo
// Two-entry FIFO that decouples RAM read returns from the host read stream.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push, pushData  write one word (ignored when full and not popping)
//   pop             remove the head word (ignored when empty)
//   headData        word at the head of the FIFO
//   empty           no words stored
//   count           number of stored words (0..2)
// ---------------------------------------------------------------------------
module bridge_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [DATA_W-1:0] headData,
    output logic              empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slots [2];
    logic              rdPtr;
    logic              wrPtr;
    logic [1:0]        used;
    logic              doPush;
    logic              doPop;

    // A push into a full FIFO is still legal when the head leaves in the
    // same cycle, because the freed slot is the one being overwritten.
    assign doPop  = pop && (used != 2'd0);
    assign doPush = push && ((used != 2'd2) || doPop);

    assign headData = slots[rdPtr];
    assign empty    = (used == 2'd0);
    assign count    = used;

    // Pointer and occupancy bookkeeping; reset leaves the FIFO empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
            used  <= 2'd0;
        end else begin
            if (doPush) begin
                wrPtr <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            used <= used + {1'b0, doPush} - {1'b0, doPop};
        end
    end

    // Storage needs no reset: occupancy alone decides which words are valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            slots[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/host_mem_bridge.sv
// ---------------------------------------------------------------------------
// host_mem_bridge
// Arbitrates a single-port RAM between a host (bulk LOAD and DUMP streams)
// and a CPU (RUN mode). The host issues commands; the CPU is stalled unless
// the bridge is in RUN.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_op/base/len  host command channel
//   in_valid/ready, in_data           host write stream (LOAD)
//   out_valid/ready, out_data         host read stream (DUMP)
//   cpu_req/we/addr/wdata, cpu_rdata  CPU access port, cpu_stall holds CPU
//   busy, done, err                   status (done is a one-cycle pulse)
//   mem_en/we/addr/wdata, mem_rdata   RAM port, read data one cycle late
// ---------------------------------------------------------------------------
module host_mem_bridge
    import host_mem_bridge_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 11,
    parameter logic [31:0] I_START = I_START_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    bridgeState_t      state;
    cmdOp_t            cmdOp;
    logic [ADDR_W-1:0] addrCnt;
    logic [ADDR_W:0]   lenCnt;
    logic [ADDR_W:0]   popCnt;
    logic              inFlight;
    logic              doneReg;
    logic              errReg;
    logic              cmdAccept;
    logic              popWord;
    logic              readIssue;
    logic [2:0]        credit;
    logic [ADDR_W-1:0] cpuIndex;
    logic              fifoEmpty;
    logic [1:0]        fifoCount;
    logic [DATA_W-1:0] fifoHead;

    assign cmdOp     = cmdOp_t'(cmd_op);
    assign cmd_ready = (state == ST_IDLE) || ((state == ST_RUN) && (cmdOp == OP_STOP));
    assign cmdAccept = cmd_valid && cmd_ready;

    assign busy      = (state != ST_IDLE);
    assign cpu_stall = (state != ST_RUN);
    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_DUMP) && !fifoEmpty;
    assign out_data  = fifoHead;
    assign popWord   = out_valid && out_ready;
    assign done      = doneReg;
    assign err       = errReg;
    assign cpu_rdata = mem_rdata;

    // The top bit picks the instruction half of RAM; the rest is the word
    // offset inside that half.
    assign cpuIndex = {cpu_addr >= I_START, cpu_addr[ADDR_W:2]};

    // Reads in flight plus stored words may never exceed the FIFO depth.
    // A pop in the same cycle frees a slot early, which is what lets a
    // continuously ready host receive one word every cycle.
    assign credit    = {2'b00, inFlight} + {1'b0, fifoCount};
    assign readIssue = (state == ST_DUMP) && (lenCnt != '0) &&
                       (credit < (3'd2 + {2'b00, popWord}));

    // RAM port steering: the host write stream, the DUMP read engine or the
    // CPU owns the port depending on the state. Nothing else reaches RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = addrCnt;
                    mem_wdata = in_data;
                end
            end
            ST_DUMP: begin
                mem_en   = readIssue;
                mem_addr = addrCnt;
            end
            ST_RUN: begin
                mem_en    = cpu_req;
                mem_we    = cpu_req && cpu_we;
                mem_addr  = cpuIndex;
                mem_wdata = cpu_wdata;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Main control FSM. done is a registered one-cycle pulse raised on the
    // cycle after an operation completes. lenCnt counts reads still to issue
    // in DUMP while popCnt counts words the host has yet to take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            addrCnt  <= '0;
            lenCnt   <= '0;
            popCnt   <= '0;
            inFlight <= 1'b0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            doneReg  <= 1'b0;
            inFlight <= readIssue;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmdOp == OP_STOP) begin
                            errReg <= 1'b1;
                        end else begin
                            errReg  <= 1'b0;
                            addrCnt <= cmd_base;
                            lenCnt  <= cmd_len;
                            popCnt  <= cmd_len;
                            if (cmdOp == OP_RUN) begin
                                state <= ST_RUN;
                            end else if (cmd_len == '0) begin
                                doneReg <= 1'b1;
                            end else if (cmdOp == OP_LOAD) begin
                                state <= ST_LOAD;
                            end else begin
                                state <= ST_DUMP;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        addrCnt <= addrCnt + 1'b1;
                        lenCnt  <= lenCnt - 1'b1;
                        if (lenCnt == LEN_ONE) begin
                            state   <= ST_IDLE;
                            doneReg <= 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (readIssue) begin
                        addrCnt <= addrCnt + 1'b1;
                        lenCnt  <= lenCnt - 1'b1;
                    end
                    if (popWord) begin
                        popCnt <= popCnt - 1'b1;
                        if (popCnt == LEN_ONE) begin
                            state   <= ST_IDLE;
                            doneReg <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cmdAccept) begin
                        state   <= ST_IDLE;
                        doneReg <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    bridge_skid_fifo #(
        .DATA_W(DATA_W)
    ) outFifo (
        .clk     (clk),
        .rst     (rst),
        .push    (inFlight),
        .pushData(mem_rdata),
        .pop     (popWord),
        .headData(fifoHead),
        .empty   (fifoEmpty),
        .count   (fifoCount)
    );

endmodule

// File: tb/tb_host_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_host_mem_bridge
// Self-checking bench for host_mem_bridge. A behavioural RAM sits on the
// DUT memory port; refMem is the expected RAM image, updated from the
// bridge's documented behaviour (host writes, CPU writes) and used to
// predict every word the host and the CPU read back.
// ---------------------------------------------------------------------------
module tb_host_mem_bridge;
    import host_mem_bridge_pkg::*;

    localparam int          DATA_W  = 32;
    localparam int          ADDR_W  = 11;
    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [31:0] I_START = 32'h0040_0000;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram    [DEPTH];
    logic [DATA_W-1:0] refMem [DEPTH];
    logic              preload;
    int                memWrites;
    int                checks;
    int                errors;
    bit                pendRead;
    logic [DATA_W-1:0] pendExp;

    host_mem_bridge #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .I_START(I_START)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_base (cmd_base),
        .cmd_len  (cmd_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= DATA_W'(i * 7 + 3);
            end
            mem_rdata <= '0;
            memWrites <= 0;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                memWrites     <= memWrites + 1;
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected RAM word index for a CPU byte address.
    function automatic int cpuIndex(input logic [31:0] a);
        int half;
        half = (a >= I_START) ? DEPTH / 2 : 0;
        return half + int'((a >> 2) % (DEPTH / 2));
    endfunction

    function automatic logic [31:0] randCpuAddr();
        logic [31:0] region;
        region = ($urandom_range(0, 1) == 1) ? I_START : 32'h0;
        return region + 32'($urandom_range(0, DEPTH / 2 - 1) * 4) + 32'($urandom_range(0, 3));
    endfunction

    // Presents one command for a cycle; called on a falling edge, returns
    // on the falling edge after the command has been sampled.
    task automatic applyStimulus(input logic [1:0] op, input int base, input int len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = ADDR_W'(base);
        cmd_len   = (ADDR_W+1)'(len);
        #1;
        checkOutput("cmdReady", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
    endtask

    task automatic runLoad(input int base, input int len, input bit randValid, input bit junkCmd);
        int addr;
        int beats;
        int cycles;
        int w0;
        addr   = base;
        beats  = 0;
        cycles = 0;
        w0     = memWrites;
        applyStimulus(OP_LOAD, base, len);
        if (len == 0) begin
            #1;
            checkOutput("zeroLenDone", done, 1);
            checkOutput("zeroLenBusy", busy, 0);
            @(negedge clk);
            #1;
            checkOutput("zeroLenNoWrite", memWrites, w0);
            checkOutput("zeroLenPulse", done, 0);
        end else begin
            while (beats < len && cycles < len * 10 + 20) begin
                in_valid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = $urandom;
                if (junkCmd) begin
                    cmd_valid = 1'b1;
                    cmd_op    = 2'($urandom_range(0, 3));
                end
                #1;
                checkOutput("loadInReady", in_ready, 1);
                checkOutput("loadEarlyDone", done, 0);
                if (junkCmd) checkOutput("loadCmdBlocked", cmd_ready, 0);
                if (in_valid) begin
                    checkOutput("loadMemEn", mem_en, 1);
                    checkOutput("loadMemWe", mem_we, 1);
                    checkOutput("loadMemAddr", mem_addr, addr % DEPTH);
                    checkOutput("loadMemWdata", mem_wdata, in_data);
                    refMem[addr % DEPTH] = in_data;
                    addr++;
                    beats++;
                end else begin
                    checkOutput("loadIdleMemEn", mem_en, 0);
                end
                @(negedge clk);
                cycles++;
            end
            in_valid  = 1'b0;
            cmd_valid = 1'b0;
            if (beats < len) checkOutput("loadTimeout", beats, len);
            #1;
            checkOutput("loadDone", done, 1);
            checkOutput("loadBusy", busy, 0);
            checkOutput("loadInReadyOff", in_ready, 0);
            checkOutput("loadErr", err, 0);
            @(negedge clk);
            #1;
            checkOutput("loadDonePulse", done, 0);
        end
    endtask

    // mode 0: random out_ready, 1: repeating 1,0,1,1, 2: always ready.
    task automatic runDump(input int base, input int len, input int mode);
        int popped;
        int cyc;
        popped = 0;
        cyc    = 0;
        applyStimulus(OP_DUMP, base, len);
        while (popped < len && cyc < len * 10 + 20) begin
            case (mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = ((cyc % 4) != 1);
                default: out_ready = 1'b1;
            endcase
            #1;
            checkOutput("dumpBusy", busy, 1);
            checkOutput("dumpEarlyDone", done, 0);
            checkOutput("dumpInReady", in_ready, 0);
            if (out_valid && out_ready) begin
                checkOutput("dumpData", out_data, refMem[(base + popped) % DEPTH]);
                if (mode == 2) checkOutput("dumpLatency", cyc, popped + 2);
                popped++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (popped < len) checkOutput("dumpTimeout", popped, len);
        #1;
        checkOutput("dumpDone", done, 1);
        checkOutput("dumpBusy", busy, 0);
        checkOutput("dumpOutValidOff", out_valid, 0);
        @(negedge clk);
        #1;
        checkOutput("dumpDonePulse", done, 0);
    endtask

    // One RUN-mode cycle; also checks the read data of the previous cycle.
    task automatic cpuCycle(input logic req, input logic we, input logic [31:0] addr,
                            input logic [DATA_W-1:0] data, input bit stopNow);
        int idx;
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = data;
        if (stopNow) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_STOP;
        end
        #1;
        if (pendRead) checkOutput("cpuRdata", cpu_rdata, pendExp);
        pendRead = 1'b0;
        checkOutput("cpuStallRun", cpu_stall, 0);
        if (stopNow) checkOutput("stopReady", cmd_ready, 1);
        if (req) begin
            idx = cpuIndex(addr);
            checkOutput("cpuMemEn", mem_en, 1);
            checkOutput("cpuMemWe", mem_we, we);
            checkOutput("cpuMemAddr", mem_addr, idx);
            if (we) begin
                checkOutput("cpuMemWdata", mem_wdata, data);
                refMem[idx] = data;
            end else begin
                pendRead = 1'b1;
                pendExp  = refMem[idx];
            end
        end else begin
            checkOutput("cpuNoReq", mem_en, 0);
        end
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic finishRun();
        #1;
        checkOutput("stopStall", cpu_stall, 1);
        checkOutput("stopDone", done, 1);
        checkOutput("stopBusy", busy, 0);
        @(negedge clk);
        #1;
        checkOutput("stopDonePulse", done, 0);
    endtask

    task automatic runCpuRandom(input int nOps);
        applyStimulus(OP_RUN, $urandom_range(0, DEPTH - 1), $urandom_range(0, 8));
        pendRead = 1'b0;
        repeat (nOps) begin
            cpuCycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), randCpuAddr(), $urandom, 1'b0);
        end
        cpuCycle(1'b1, 1'b1, randCpuAddr(), $urandom, 1'b1);
        finishRun();
    endtask

    // Main sequence: reset, directed scenarios, randomized rounds, then a
    // full comparison of the RAM image against the reference.
    initial begin
        int base;
        int len;
        logic [DATA_W-1:0] word;
        checks    = 0;
        errors    = 0;
        pendRead  = 1'b0;
        rst       = 1'b1;
        preload   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_base  = '0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = DATA_W'(i * 7 + 3);

        repeat (2) @(negedge clk);
        preload = 1'b0;
        #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstStall", cpu_stall, 1);
        checkOutput("rstInReady", in_ready, 0);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstMemEn", mem_en, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // CPU requests outside RUN must not reach the RAM.
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        #1;
        checkOutput("idleCpuMemEn", mem_en, 0);
        checkOutput("idleCpuStall", cpu_stall, 1);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        @(negedge clk);

        // Three-word LOAD then DUMP with a toggling host ready.
        runLoad(5, 3, 1'b0, 1'b0);
        runDump(5, 3, 1);

        // LOAD across the top of the address space.
        runLoad(DEPTH - 1, 2, 1'b0, 1'b0);
        runDump(DEPTH - 3, 6, 2);

        // RUN: write and read back one instruction word, then STOP.
        applyStimulus(OP_RUN, 0, 0);
        word      = $urandom;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = I_START + 32'd8;
        cpu_wdata = word;
        #1;
        checkOutput("runStall", cpu_stall, 0);
        checkOutput("runWrAddr", mem_addr, DEPTH / 2 + 2);
        checkOutput("runWrWe", mem_we, 1);
        refMem[DEPTH / 2 + 2] = word;
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        checkOutput("runRdAddr", mem_addr, DEPTH / 2 + 2);
        checkOutput("runRdWe", mem_we, 0);
        @(negedge clk);
        cpu_req   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        #1;
        checkOutput("runRdData", cpu_rdata, word);
        checkOutput("runLoadBlocked", cmd_ready, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        checkOutput("runStaysRun", cpu_stall, 0);
        @(negedge clk);
        cpuCycle(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b1);
        finishRun();

        // STOP in IDLE flags an error; the next accepted command clears it.
        applyStimulus(OP_STOP, 0, 0);
        #1;
        checkOutput("stopIdleErr", err, 1);
        checkOutput("stopIdleBusy", busy, 0);
        checkOutput("stopIdleDone", done, 0);
        @(negedge clk);
        runLoad(40, 0, 1'b0, 1'b0);
        checkOutput("errCleared", err, 0);
        runLoad(100, 4, 1'b1, 1'b1);
        runDump(100, 0, 2);

        // Reset in the middle of a DUMP abandons it without a done pulse.
        applyStimulus(OP_DUMP, 0, 10);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("preRstOutValid", out_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("midRstOutValid", out_valid, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("postRstDone", done, 0);
        @(negedge clk);
        #1;
        checkOutput("postRstDone2", done, 0);
        runDump(5, 3, 1);

        // Randomized rounds of LOAD, DUMP and CPU traffic.
        for (int r = 0; r < 6; r++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(1, 12);
            runLoad(base, len, 1'b1, 1'b0);
            runDump(base, $urandom_range(1, len), 0);
            runCpuRandom(10);
            runDump($urandom_range(0, DEPTH - 1), $urandom_range(1, 8), $urandom_range(0, 2));
        end

        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("ramImage", ram[i], refMem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
